// File: rtl/mult_div_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : mult_div_ctrl_pkg
// Brief    : Operation codes and shared types for the HI/LO multiply/divide unit
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mult_div_ctrl_pkg;

    localparam logic [3:0] MULT_NOTHING       = 4'd0;
    localparam logic [3:0] MULT_READ_LO       = 4'd1;
    localparam logic [3:0] MULT_READ_HI       = 4'd2;
    localparam logic [3:0] MULT_WRITE_LO      = 4'd3;
    localparam logic [3:0] MULT_WRITE_HI      = 4'd4;
    localparam logic [3:0] MULT_MULT          = 4'd5;
    localparam logic [3:0] MULT_SIGNED_MULT   = 4'd6;
    localparam logic [3:0] MULT_DIVIDE        = 4'd7;
    localparam logic [3:0] MULT_SIGNED_DIVIDE = 4'd8;

    typedef enum logic {
        STEP_MUL = 1'b0,
        STEP_DIV = 1'b1
    } step_mode_e;

    // Codes above MULT_SIGNED_DIVIDE are treated exactly like MULT_NOTHING.
    function automatic logic is_active_func(input logic [3:0] f);
        return (f != MULT_NOTHING) && (f <= MULT_SIGNED_DIVIDE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mult_div_step.sv
//------------------------------------------------------------------------------
// Module   : mult_div_step
// Brief    : One iteration of shift-add multiply or restoring divide
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mult_div_step
    import mult_div_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] op_i,
    input  logic [WIDTH-1:0] arg_i,
    input  step_mode_e       mode_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] op_o
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_rem;
    logic [WIDTH:0] w_diff;

    always_comb begin
        w_sum  = {1'b0, acc_i} + (op_i[0] ? {1'b0, arg_i} : '0);
        w_rem  = {acc_i, op_i[WIDTH-1]};
        w_diff = w_rem - {1'b0, arg_i};
        acc_o  = acc_i;
        op_o   = op_i;
        if (mode_i == STEP_DIV) begin
            // Partial remainder stays below the divisor, so a set top bit means borrow.
            if (w_diff[WIDTH]) begin
                acc_o = w_rem[WIDTH-1:0];
                op_o  = {op_i[WIDTH-2:0], 1'b0};
            end else begin
                acc_o = w_diff[WIDTH-1:0];
                op_o  = {op_i[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_o = w_sum[WIDTH:1];
            op_o  = {w_sum[0], op_i[WIDTH-1:1]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/mult_div_ctrl.sv
//------------------------------------------------------------------------------
// Module   : mult_div_ctrl
// Brief    : HI/LO multiply/divide sequencer with pipeline stall request
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mult_div_ctrl
    import mult_div_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       mult_func,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] c_mult,
    output logic             pause_out,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 2);

    logic [WIDTH-1:0] hi_q,  hi_d;
    logic [WIDTH-1:0] lo_q,  lo_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] op_q,  op_d;
    logic [WIDTH-1:0] arg_q, arg_d;
    logic [CW-1:0]    count_q, count_d;
    step_mode_e       mode_q, mode_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic             div0_q, div0_d;

    logic [WIDTH-1:0]   w_acc_nxt;
    logic [WIDTH-1:0]   w_op_nxt;
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic [2*WIDTH-1:0] w_prod;

    mult_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_i  (acc_q),
        .op_i   (op_q),
        .arg_i  (arg_q),
        .mode_i (mode_q),
        .acc_o  (w_acc_nxt),
        .op_o   (w_op_nxt)
    );

    always_comb begin
        w_signed = (mult_func == MULT_SIGNED_MULT) || (mult_func == MULT_SIGNED_DIVIDE);
        w_a_neg  = w_signed && a_in[WIDTH-1];
        w_b_neg  = w_signed && b_in[WIDTH-1];
        w_a_abs  = w_a_neg ? -a_in : a_in;
        w_b_abs  = w_b_neg ? -b_in : b_in;
        w_prod   = neg_lo_q ? -{acc_q, op_q} : {acc_q, op_q};

        hi_d     = hi_q;
        lo_d     = lo_q;
        acc_d    = acc_q;
        op_d     = op_q;
        arg_d    = arg_q;
        count_d  = count_q;
        mode_d   = mode_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        div0_d   = div0_q;

        if (count_q == '0) begin
            case (mult_func)
                MULT_WRITE_HI: hi_d = a_in;
                MULT_WRITE_LO: lo_d = a_in;
                MULT_MULT, MULT_SIGNED_MULT: begin
                    count_d  = CW'(WIDTH + 1);
                    mode_d   = STEP_MUL;
                    acc_d    = '0;
                    op_d     = w_b_abs;
                    arg_d    = w_a_abs;
                    neg_lo_d = w_a_neg ^ w_b_neg;
                    neg_hi_d = 1'b0;
                    div0_d   = 1'b0;
                end
                MULT_DIVIDE, MULT_SIGNED_DIVIDE: begin
                    count_d  = CW'(WIDTH + 1);
                    mode_d   = STEP_DIV;
                    acc_d    = '0;
                    op_d     = w_a_abs;
                    arg_d    = w_b_abs;
                    div0_d   = (b_in == '0);
                    neg_lo_d = (w_a_neg ^ w_b_neg) && (b_in != '0);
                    neg_hi_d = w_a_neg;
                end
                default: ;
            endcase
        end else if (count_q >= CW'(2)) begin
            acc_d   = w_acc_nxt;
            op_d    = w_op_nxt;
            count_d = count_q - CW'(1);
        end else begin
            count_d = '0;
            if (mode_q == STEP_MUL) begin
                hi_d = w_prod[2*WIDTH-1:WIDTH];
                lo_d = w_prod[WIDTH-1:0];
            end else begin
                // A zero divisor leaves |dividend| in acc; the sign restore recovers a_in.
                lo_d = div0_q ? '1 : (neg_lo_q ? -op_q : op_q);
                hi_d = neg_hi_q ? -acc_q : acc_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q     <= '0;
            lo_q     <= '0;
            acc_q    <= '0;
            op_q     <= '0;
            arg_q    <= '0;
            count_q  <= '0;
            mode_q   <= STEP_MUL;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            acc_q    <= acc_d;
            op_q     <= op_d;
            arg_q    <= arg_d;
            count_q  <= count_d;
            mode_q   <= mode_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            div0_q   <= div0_d;
        end
    end

    always_comb begin
        busy      = (count_q != '0);
        pause_out = busy && is_active_func(mult_func);
        case (mult_func)
            MULT_READ_HI: c_mult = hi_q;
            MULT_READ_LO: c_mult = lo_q;
            default:      c_mult = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mult_div_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_mult_div_ctrl
// Brief    : Self-checking bench for mult_div_ctrl against an arithmetic model
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mult_div_ctrl;
    import mult_div_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  mult_func;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] c_mult;
    logic        pause_out;
    logic        busy;

    int errors = 0;
    int checks = 0;

    mult_div_ctrl #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .mult_func (mult_func),
        .a_in      (a_in),
        .b_in      (b_in),
        .c_mult    (c_mult),
        .pause_out (pause_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo);
        logic [63:0] p;
        int sa;
        int sb;
        sa = a;
        sb = b;
        p  = '0;
        hi = '0;
        lo = '0;
        case (f)
            MULT_MULT: begin
                p = {32'b0, a} * {32'b0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            MULT_SIGNED_MULT: begin
                p = longint'(sa) * longint'(sb);
                hi = p[63:32];
                lo = p[31:0];
            end
            MULT_DIVIDE: begin
                if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
                else begin lo = a / b; hi = a % b; end
            end
            default: begin
                if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = 32'h8000_0000; hi = 0; end
                else begin lo = sa / sb; hi = sa % sb; end
            end
        endcase
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        @(negedge clk);
        mult_func = MULT_READ_LO;
        #1;
        chk({tag, "_pause"}, {31'b0, pause_out}, 32'd0);
        chk({tag, "_lo"}, c_mult, exp_lo);
        @(negedge clk);
        mult_func = MULT_READ_HI;
        #1;
        chk({tag, "_hi"}, c_mult, exp_hi);
        @(negedge clk);
        mult_func = MULT_NOTHING;
    endtask

    task automatic wait_idle(input string tag);
        int cyc;
        cyc = 0;
        while (busy && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, cyc, 32'd33);
    endtask

    task automatic run_op(input string tag, input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh;
        logic [31:0] el;
        model(f, a, b, eh, el);
        @(negedge clk);
        mult_func = f;
        a_in = a;
        b_in = b;
        @(negedge clk);
        mult_func = MULT_NOTHING;
        a_in = $urandom;
        b_in = $urandom;
        wait_idle(tag);
        read_hilo(tag, eh, el);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] eh;
        logic [31:0] el;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [3:0]  rf;
        int n;

        rst = 1'b1;
        mult_func = MULT_NOTHING;
        a_in = '0;
        b_in = '0;
        repeat (2) @(negedge clk);
        mult_func = MULT_READ_LO;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_pause", {31'b0, pause_out}, 32'd0);
        chk("rst_lo", c_mult, 32'd0);
        @(negedge clk);
        mult_func = MULT_READ_HI;
        #1;
        chk("rst_hi", c_mult, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mult_func = MULT_NOTHING;

        run_op("multu_ff", MULT_MULT, 32'hFFFF_FFFF, 32'h2);
        run_op("mult_neg", MULT_SIGNED_MULT, 32'hFFFF_FFFD, 32'd7);
        run_op("div_neg", MULT_SIGNED_DIVIDE, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_zero", MULT_DIVIDE, 32'd100, 32'd0);
        run_op("div_ovf", MULT_SIGNED_DIVIDE, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_zero_s", MULT_SIGNED_DIVIDE, 32'hFFFF_FF00, 32'd0);

        // MTHI/MTLO while idle must not stall.
        @(negedge clk);
        mult_func = MULT_WRITE_HI;
        a_in = 32'h1234;
        #1;
        chk("mthi_pause", {31'b0, pause_out}, 32'd0);
        @(negedge clk);
        mult_func = MULT_WRITE_LO;
        a_in = 32'h5678;
        #1;
        chk("mtlo_pause", {31'b0, pause_out}, 32'd0);
        read_hilo("mtx", 32'h1234, 32'h5678);

        // MFLO issued mid-operation stalls until the final result is readable.
        model(MULT_MULT, 32'hDEAD_BEEF, 32'h1234_5678, eh, el);
        @(negedge clk);
        mult_func = MULT_MULT;
        a_in = 32'hDEAD_BEEF;
        b_in = 32'h1234_5678;
        @(negedge clk);
        mult_func = MULT_NOTHING;
        repeat (5) @(negedge clk);
        mult_func = MULT_READ_LO;
        #1;
        n = 0;
        while (pause_out && n < 200) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk("mflo_pause_cycles", n, 32'd28);
        chk("mflo_after_pause", c_mult, el);
        @(negedge clk);
        mult_func = MULT_NOTHING;

        // A held op is accepted on the first idle cycle with no dead cycle.
        @(negedge clk);
        mult_func = MULT_MULT;
        a_in = 32'd9;
        b_in = 32'd11;
        @(negedge clk);
        mult_func = MULT_DIVIDE;
        a_in = 32'd1000;
        b_in = 32'd7;
        #1;
        n = 0;
        while (pause_out && n < 200) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk("b2b_pause_cycles", n, 32'd33);
        @(negedge clk);
        chk("b2b_accept", {31'b0, busy}, 32'd1);
        mult_func = MULT_NOTHING;
        wait_idle("b2b");
        read_hilo("b2b", 32'd6, 32'd142);

        // Reset in the middle of a divide aborts it and clears HI/LO.
        @(negedge clk);
        mult_func = MULT_DIVIDE;
        a_in = 32'hFFFF_0000;
        b_in = 32'd3;
        @(negedge clk);
        mult_func = MULT_NOTHING;
        repeat (23) @(negedge clk);
        rst = 1'b1;
        mult_func = MULT_READ_LO;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_pause", {31'b0, pause_out}, 32'd0);
        chk("abort_lo", c_mult, 32'd0);
        mult_func = MULT_READ_HI;
        #1;
        chk("abort_hi", c_mult, 32'd0);
        run_op("post_abort", MULT_MULT, 32'd6, 32'd7);

        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 3))
                0:       rf = MULT_MULT;
                1:       rf = MULT_SIGNED_MULT;
                2:       rf = MULT_DIVIDE;
                default: rf = MULT_SIGNED_DIVIDE;
            endcase
            ra = rnd_operand();
            rb = rnd_operand();
            run_op($sformatf("rnd%0d_f%0d", i, rf), rf, ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
